// File: rtl/nvram_pkg.sv
// nvram_pkg: shared sweep-state encoding for the shadowed NVRAM model
package nvram_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STORE = 2'd1, RECALL = 2'd2} state_t;
endpackage

// File: rtl/nvram_array.sv
// nvram_array: DATA_W x 2**ADDR_W array, one sync write port (we/wa/wd), two comb read ports (ra0/rd0, ra1/rd1)
module nvram_array #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1
);
  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: INIT_VAL};
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/nvram_shadow.sv
// nvram_shadow: working RAM (CPU a/i/o/ce_n/rw_n) backed by shadow RAM (host ext_*), store/recall sweeps reported on busy/done
module nvram_shadow
  import nvram_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int AUTO_RECALL = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] o,
  input  logic              ce_n,
  input  logic              rw_n,
  input  logic              recall_n,
  input  logic              store,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] ext_a,
  input  logic [DATA_W-1:0] ext_din,
  input  logic              ext_we,
  output logic [DATA_W-1:0] ext_dout
);
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic done_q, done_n, store_d, recall_n_d;
  logic st_edge, rc_edge;
  logic ram_we, sh_we;
  logic [ADDR_W-1:0] ram_wa, sh_wa;
  logic [DATA_W-1:0] ram_wd, sh_wd, ram_cnt, sh_cnt;
  assign st_edge = store & ~store_d;
  assign rc_edge = ~recall_n & recall_n_d;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state      <= AUTO_RECALL != 0 ? RECALL : IDLE;
      cnt        <= '0;
      done_q     <= 1'b0;
      store_d    <= 1'b1;
      recall_n_d <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      done_q     <= done_n;
      store_d    <= store;
      recall_n_d <= recall_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    if (state == IDLE)
      state_n = rc_edge ? RECALL : st_edge ? STORE : IDLE;
    else begin
      cnt_n = cnt + 1'b1;
      if (&cnt) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end
  assign busy     = reset_n ? state != IDLE : AUTO_RECALL != 0;
  assign done     = done_q & reset_n;
  // Every array write is gated by reset_n so a reset edge never copies a word.
  assign ram_we = reset_n & (state == RECALL | (state == IDLE & ~ce_n & ~rw_n));
  assign ram_wa = state == RECALL ? cnt : a;
  assign ram_wd = state == RECALL ? sh_cnt : i;
  assign sh_we  = reset_n & (state == STORE | (state == IDLE & ext_we));
  assign sh_wa  = state == STORE ? cnt : ext_a;
  assign sh_wd  = state == STORE ? ram_cnt : ext_din;
  nvram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL(INIT_VAL)) u_ram (
    .clk(clk), .we(ram_we), .wa(ram_wa), .wd(ram_wd),
    .ra0(a), .rd0(o), .ra1(cnt), .rd1(ram_cnt)
  );
  nvram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL(INIT_VAL)) u_shadow (
    .clk(clk), .we(sh_we), .wa(sh_wa), .wd(sh_wd),
    .ra0(ext_a), .rd0(ext_dout), .ra1(cnt), .rd1(sh_cnt)
  );
endmodule

// File: tb/tb_nvram_shadow.sv
// tb_nvram_shadow: directed self-checking bench for nvram_shadow with default parameters
module tb_nvram_shadow;
  logic clk = 1'b0, reset_n, ce_n, rw_n, recall_n, store, ext_we, busy, done;
  logic [7:0] a, ext_a;
  logic [3:0] i, o, ext_din, ext_dout;
  int checks = 0, errors = 0, done_cnt = 0;
  nvram_shadow dut (
    .clk(clk), .reset_n(reset_n), .a(a), .i(i), .o(o), .ce_n(ce_n), .rw_n(rw_n),
    .recall_n(recall_n), .store(store), .busy(busy), .done(done),
    .ext_a(ext_a), .ext_din(ext_din), .ext_we(ext_we), .ext_dout(ext_dout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic cpu_write(input logic [7:0] ad, input logic [3:0] d);
    a = ad; i = d; ce_n = 1'b0; rw_n = 1'b0;
    @(negedge clk);
    ce_n = 1'b1; rw_n = 1'b1;
  endtask
  function automatic logic [3:0] prior_sh(input int k);
    return k == 200 ? 4'hA : k == 5 ? 4'h3 : k == 3 ? 4'h5 : 4'hF;
  endfunction
  initial begin
    int n, bad, d0;
    logic [7:0] kk;
    reset_n = 1'b0; ce_n = 1'b1; rw_n = 1'b1; recall_n = 1'b1; store = 1'b0;
    ext_we = 1'b0; a = '0; i = '0; ext_a = '0; ext_din = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1);
    chk("reset_done", done, 0);
    reset_n = 1'b1;
    wait_sweep(n);
    chk("auto_recall_len", n, 256);
    chk("auto_recall_done", done, 1);
    @(negedge clk);
    chk("auto_recall_done_low", done, 0);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      a = 8'(k); #1;
      if (o !== 4'hF) bad++;
    end
    chk("init_all_F", bad, 0);
    @(negedge clk);
    cpu_write(8'd5, 4'h3);
    a = 8'd5; #1;
    chk("cpu_write_ram5", o, 4'h3);
    store = 1'b1;
    @(negedge clk);
    store = 1'b0;
    chk("store_busy", busy, 1);
    wait_sweep(n);
    chk("store_len", n, 256);
    chk("store_done", done, 1);
    ext_a = 8'd5; #1;
    chk("store_shadow5", ext_dout, 4'h3);
    ext_a = 8'd6; #1;
    chk("store_shadow6", ext_dout, 4'hF);
    @(negedge clk);
    ext_a = 8'd200; ext_din = 4'hA; ext_we = 1'b1;
    @(negedge clk);
    ext_we = 1'b0; #1;
    chk("host_write200", ext_dout, 4'hA);
    a = 8'd200; #1;
    chk("ram200_before_recall", o, 4'hF);
    recall_n = 1'b0;
    @(negedge clk);
    recall_n = 1'b1;
    wait_sweep(n);
    chk("recall_len", n, 256);
    a = 8'd200; #1;
    chk("recall_ram200", o, 4'hA);
    a = 8'd5; #1;
    chk("recall_ram5", o, 4'h3);
    @(negedge clk);
    cpu_write(8'd9, 4'h2);
    store = 1'b1; recall_n = 1'b0;
    @(negedge clk);
    store = 1'b0; recall_n = 1'b1;
    wait_sweep(n);
    chk("simul_len", n, 256);
    ext_a = 8'd9; a = 8'd9; #1;
    chk("simul_shadow9_kept", ext_dout, 4'hF);
    chk("simul_ram9_recalled", o, 4'hF);
    @(negedge clk);
    cpu_write(8'd3, 4'h5);
    d0 = done_cnt;
    store = 1'b1;
    @(negedge clk);
    store = 1'b0;
    repeat (10) @(negedge clk);
    a = 8'd7; i = 4'h1; ce_n = 1'b0; rw_n = 1'b0;
    ext_a = 8'd2; ext_din = 4'h6; ext_we = 1'b1; store = 1'b1;
    @(negedge clk);
    ce_n = 1'b1; rw_n = 1'b1; ext_we = 1'b0; store = 1'b0;
    wait_sweep(n);
    chk("busy_sweep_len", n, 245);
    repeat (5) @(negedge clk);
    chk("busy_no_requeue", busy, 0);
    chk("busy_one_done", done_cnt - d0, 1);
    a = 8'd7; ext_a = 8'd2; #1;
    chk("busy_cpu_ignored", o, 4'hF);
    chk("busy_host_ignored", ext_dout, 4'hF);
    ext_a = 8'd3; #1;
    chk("busy_store_shadow3", ext_dout, 4'h5);
    @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      kk = 8'(k);
      cpu_write(kk, kk[3:0] ^ 4'h5);
    end
    store = 1'b1;
    @(negedge clk);
    store = 1'b0;
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_busy", busy, 1);
    chk("midreset_done", done, 0);
    reset_n = 1'b1;
    wait_sweep(n);
    chk("midreset_recall_len", n, 256);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      kk = 8'(k);
      a = kk; #1;
      if (o !== (k < 100 ? kk[3:0] ^ 4'h5 : prior_sh(k))) bad++;
    end
    chk("midreset_ram_image", bad, 0);
    a = 8'd99; #1;
    chk("midreset_ram99", o, 4'h6);
    a = 8'd100; #1;
    chk("midreset_ram100", o, 4'hF);
    a = 8'd200; ext_a = 8'd150; #1;
    chk("midreset_ram200", o, 4'hA);
    chk("midreset_shadow150", ext_dout, 4'hF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nvram_shadow.md
# nvram_shadow

Parametrised, clocked model of a shadowed nonvolatile static RAM: a volatile working array the CPU reads and writes, backed by a shadow array that survives `reset_n`. A store copies working to shadow, a recall copies shadow to working, each as a one-word-per-clock sweep, and an optional automatic recall follows reset. A side port gives the host direct access to the shadow array so saved tables can be persisted and reloaded. It replaces the fixed 256x4 asynchronous NVRAM model in the game-board memory map.

## Interface
- `DATA_W`, 4: word width.
- `ADDR_W`, 8: address width; depth `DEPTH = 2**ADDR_W`.
- `AUTO_RECALL`, 1: 1 = a recall sweep starts immediately out of reset.
- `INIT_VAL`, all ones: initial content of both arrays at time zero (simulation init only).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `a`  in  ADDR_W  CPU address.
- `i`  in  DATA_W  CPU write data.
- `o`  out  DATA_W  CPU read data, combinational `ram[a]`.
- `ce_n`  in  1  chip enable, active low.
- `rw_n`  in  1  0 = write, 1 = read.
- `recall_n`  in  1  recall request; its falling edge triggers a recall.
- `store`  in  1  store request; its rising edge triggers a store.
- `busy`  out  1  a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `ext_a`  in  ADDR_W  host shadow address.
- `ext_din`  in  DATA_W  host shadow write data.
- `ext_we`  in  1  host shadow write strobe.
- `ext_dout`  out  DATA_W  combinational `shadow[ext_a]`.

## Operation
- **Reset.** Neither array is cleared by reset. Reset affects only control state:
  - `state` resets to RECALL if `AUTO_RECALL`, otherwise to IDLE.
  - `cnt`, `done`, and `recall_n_d` reset to 0; `store_d` resets to 1.
  - While reset is held, `busy` = `AUTO_RECALL` and `done` = 0.
- **Edge detection** uses registered copies of the request inputs:
  - `st_edge = store & !store_d`
  - `rc_edge = !recall_n & recall_n_d`
  - Because of the reset values above, a request that is already asserted as reset releases is not an edge.
- **States:** IDLE, STORE, RECALL.
  - IDLE, `rc_edge` → RECALL with `cnt` = 0. Recall wins if both edges occur in the same cycle.
  - IDLE, `st_edge` → STORE with `cnt` = 0.
  - STORE: `shadow[cnt] <= ram[cnt]` each cycle.
  - RECALL: `ram[cnt] <= shadow[cnt]` each cycle.
  - In STORE or RECALL, `cnt` increments each cycle. When `cnt == DEPTH-1` the sweep returns to IDLE, `done <= 1`, and `cnt` wraps to 0.
  - Edges that arrive during a sweep are dropped, not queued.
- **CPU write:** `ram[a] <= i` when `!ce_n & !rw_n & state == IDLE`. The write is ignored during a sweep.
- **CPU read:** `o` = `ram[a]` at all times, independent of `ce_n`.
- **Host write:** `shadow[ext_a] <= ext_din` when `ext_we & state == IDLE`. The write is ignored while busy.
- **Reset mid-sweep:** the sweep is abandoned and restarts per `AUTO_RECALL`. Words already copied stay copied.

## Timing
- **CPU write:** takes effect at the clock edge where it is sampled. `o` shows the new value after that edge when `a` is unchanged.
- **Sweep latency:** the request edge is sampled at edge k, and `busy` rises after edge k.
  - Copies happen at edges k+1 through k+DEPTH.
  - `busy` falls after edge k+DEPTH, and `done` is high for exactly that one following cycle.
  - `busy` therefore lasts DEPTH cycles; with the defaults that is 256.
- **Automatic recall:** with `AUTO_RECALL` = 1, the copies occur on the first DEPTH edges after `reset_n` rises.
- **Back-to-back sweeps:** `store_d` and `recall_n_d` update every cycle, including while busy. A new sweep therefore needs a fresh edge after `busy` has fallen.

## Structure
- **Shared package `nvram_pkg`:** state encoding (IDLE=0, STORE=1, RECALL=2).
- **Sub-module `nvram_array`:** parametrised DATA_W x DEPTH array with one synchronous write port and two combinational read ports. It is instantiated twice: the working array and the shadow array.
- **Top-level contents:** the FSM, counter, edge detectors, and write-enable muxing. The top selects each array's write address, data, and enable from the CPU, host, or sweep source.

## Test plan
- **Defaults, AUTO_RECALL = 1:**
  - Release reset → `busy` = 1 for 256 cycles, then `done` pulses once.
  - Afterwards `o` = 4'hF at every address.
- **Store sweep:**
  - Write `ram[5]` = 4'h3, then raise `store` for one cycle.
  - After `done`, `ext_a` = 5 gives `ext_dout` = 4'h3.
- **Recall sweep:**
  - Host-write `shadow[200]` = 4'hA, then pulse `recall_n` low.
  - After 256 cycles, `a` = 200 gives `o` = 4'hA.
- **Simultaneous requests:** `store` rises and `recall_n` falls in the same cycle → a recall sweep runs and the shadow array is unchanged.
- **Accesses during a sweep:**
  - Issue a CPU write (`a` = 7, `i` = 4'h1), a host write, and a second `store` edge while `busy` = 1.
  - All three are ignored: `ram[7]` and `shadow` keep their values, and exactly one `done` pulse occurs.
- **Reset mid-store:**
  - Assert `reset_n` = 0 at `cnt` = 100, then release it.
  - A recall runs: `ram[0..99]` equals the newly stored values, and `ram[100..255]` equals the prior shadow contents.
